voice_slot_scheduler: RTL and testbench
=======================================

Name: voice_slot_scheduler

Overview:
- Polyphonic voice controller that time-multiplexes NVOICES phase accumulators into the single pipelined quarter-wave sine datapath.
- Accepts note-on/note-off commands and allocates, retriggers or frees voices.
- Issues one voice per clk_en cycle in round-robin order as a (phase, midi, valid) triple for the sine pipeline's i_phase/i_midi/i_valid inputs.

Parameters:
- NVOICES, 10, number of voice slots; equals the sine pipeline bank count.
- VIDX_W, 4, width of the voice index; must satisfy 2**VIDX_W >= NVOICES.
- PHASE_W, 24, phase accumulator and increment width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- clk_en  in  1  sample-rate enable shared with the sine pipeline.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid.
- i_cmd_on  in  1  1 = note-on, 0 = note-off.
- i_cmd_midi  in  7  MIDI note number.
- i_cmd_inc  in  PHASE_W  phase increment (tuning word); note-on only.
- i_all_off  in  1  panic: deactivate all voices.
- o_phase  out  PHASE_W  phase to the sine pipeline.
- o_midi  out  7  MIDI tag to the sine pipeline.
- o_valid  out  1  issued slot holds an active voice.
- o_voice  out  VIDX_W  issued slot index.
- o_drop  out  1  one-cycle pulse: note-on rejected because no voice was free.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Outputs: o_phase=0, o_midi=0, o_valid=0, o_voice=0, o_drop=0.
  - State: all active flags, phases, increments and MIDI tags = 0; slot counter = 0; FSM = IDLE.
  - Reset overrides every other input, including a command in flight.
- Voice table, per slot: active (1 b), midi (7 b), inc (PHASE_W), phase (PHASE_W).
- Issue path (only on cycles with clk_en=1):
  - For slot s = slot counter, register o_voice<=s, o_valid<=active[s], o_midi<=midi[s], o_phase<=phase[s] (the pre-increment value).
  - If active[s], update phase[s] <= phase[s]+inc[s] mod 2**PHASE_W.
  - Advance the slot counter: s -> s+1, with NVOICES-1 wrapping to 0.
  - Latency is 1 clk from slot selection to outputs.
  - With clk_en=0: all issue outputs, the counter and the phases hold.
- Command FSM (runs every clk, independent of clk_en):
  - o_cmd_ready = (state==IDLE), combinational from state.
  - IDLE: on i_cmd_valid & o_cmd_ready, latch on/midi/inc and go to SEARCH with k=0.
  - SEARCH:
    - One slot examined per cycle, k=0..NVOICES-1.
    - Record the first slot with active & midi==cmd_midi (match).
    - Record the lowest-index slot with !active (free).
    - After k=NVOICES-1, go to COMMIT.
  - COMMIT (1 cycle), then IDLE:
    - Note-on with match: retrigger that slot; inc<=cmd_inc, phase<=0, stays active.
    - Note-on, no match, free found: that slot gets active<=1, midi<=cmd_midi, inc<=cmd_inc, phase<=0.
    - Note-on, no match, no free: no table change; o_drop=1 for this cycle only.
    - Note-off with match: active<=0, phase<=0. Note-off without match: no-op.
  - Throughput: one command per NVOICES+2 cycles; ready deasserts the cycle after acceptance.
- Conflicts:
  - If a COMMIT write and an issue-path phase update hit the same slot in the same cycle, the COMMIT write wins.
  - The issue path reads pre-commit values that cycle.
- i_all_off=1:
  - Next edge: all active<=0, phases<=0, FSM<=IDLE (any in-flight command is discarded, no o_drop).
  - Takes priority over COMMIT. A command presented with i_all_off high is not accepted.
- Only one slot may hold a given active midi; the retrigger rule guarantees this.

Test Plan:
- Reset, then clk_en=1 with no commands for 30 cycles -> o_valid=0 throughout; o_voice cycles 0..9 and repeats; o_cmd_ready=1.
- Note-on midi=69 inc=0x000100 -> ready low for 11 cycles; slot 0 active. Subsequent issues of slot 0 show o_valid=1, o_midi=69, o_phase=0x000000, 0x000100, 0x000200.
- Note-on midi=60 inc=0x800000 -> slot 1 phases 0x000000, 0x800000, 0x000000 (wrap). With clk_en held low for 5 cycles mid-run, outputs and phase stay frozen.
- Fill all 10 slots with distinct notes, then an 11th note-on midi=100 -> o_drop pulses exactly 1 cycle and the table is unchanged. Then note-off 69 -> slot 0 o_valid=0; note-off 127 (not present) -> no change.
- Note-on 69 while 69 is active in slot 3 -> slot 3 phase restarts at 0 with the new inc; no second slot allocated.
- i_all_off during SEARCH -> FSM IDLE and all o_valid=0 on the next cycle, no o_drop. Separately, rst=0 during COMMIT -> all outputs 0, table cleared, ready=1 after release.

Source files
------------

// File: rtl/voice_slot_scheduler.sv
// Polyphonic voice slot scheduler.
// Holds NVOICES phase accumulators and issues one voice per clk_en cycle, in
// round-robin order, to a shared pipelined sine datapath. A small command FSM
// scans the voice table to retrigger, allocate or free voices on note-on and
// note-off requests.
module voice_slot_scheduler #(
    parameter int NVOICES = 10,
    parameter int VIDX_W  = 4,
    parameter int PHASE_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic               i_cmd_on,
    input  logic [6:0]         i_cmd_midi,
    input  logic [PHASE_W-1:0] i_cmd_inc,
    input  logic               i_all_off,
    output logic [PHASE_W-1:0] o_phase,
    output logic [6:0]         o_midi,
    output logic               o_valid,
    output logic [VIDX_W-1:0]  o_voice,
    output logic               o_drop
);

    localparam logic [VIDX_W-1:0] LAST_SLOT = VIDX_W'(NVOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_COMMIT
    } state_t;

    // Voice table
    logic               active_tab [NVOICES];
    logic [6:0]         midi_tab   [NVOICES];
    logic [PHASE_W-1:0] inc_tab    [NVOICES];
    logic [PHASE_W-1:0] phase_tab  [NVOICES];

    // Round-robin issue pointer
    logic [VIDX_W-1:0]  slot;

    // Command FSM state and latched command
    state_t             state;
    logic [VIDX_W-1:0]  k;
    logic               cmd_on;
    logic [6:0]         cmd_midi;
    logic [PHASE_W-1:0] cmd_inc;
    logic               match_found;
    logic [VIDX_W-1:0]  match_idx;
    logic               free_found;
    logic [VIDX_W-1:0]  free_idx;

    // Decoded table writes for the COMMIT cycle
    logic               in_commit;
    logic               do_retrig;
    logic               do_alloc;
    logic               do_off;
    logic               do_drop;
    logic [VIDX_W-1:0]  commit_idx;

    assign o_cmd_ready = (state == ST_IDLE);

    assign in_commit  = (state == ST_COMMIT);
    assign do_retrig  = in_commit &&  cmd_on &&  match_found;
    assign do_alloc   = in_commit &&  cmd_on && !match_found &&  free_found;
    assign do_drop    = in_commit &&  cmd_on && !match_found && !free_found;
    assign do_off     = in_commit && !cmd_on &&  match_found;
    assign commit_idx = match_found ? match_idx : free_idx;

    // Command FSM: accept, scan one slot per cycle, then commit for one cycle.
    always_ff @(posedge clk) begin
        // NOTE: all state in clocked blocks is assigned with <= so every
        // register samples the pre-edge values of the others.
        if (!rst) begin
            state       <= ST_IDLE;
            k           <= '0;
            cmd_on      <= 1'b0;
            cmd_midi    <= '0;
            cmd_inc     <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            o_drop      <= 1'b0;
        end else if (i_all_off) begin
            // Panic discards any command in flight without reporting a drop.
            state  <= ST_IDLE;
            o_drop <= 1'b0;
        end else begin
            o_drop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        cmd_on      <= i_cmd_on;
                        cmd_midi    <= i_cmd_midi;
                        cmd_inc     <= i_cmd_inc;
                        k           <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        state       <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (active_tab[k] && (midi_tab[k] == cmd_midi) && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= k;
                    end
                    if (!active_tab[k] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= k;
                    end
                    if (k == LAST_SLOT) begin
                        state <= ST_COMMIT;
                    end else begin
                        k <= k + VIDX_W'(1);
                    end
                end
                ST_COMMIT: begin
                    o_drop <= do_drop;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Voice table and issue path: round-robin issue, then commit and panic writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the table is small and must start silent, so every entry
            // is cleared explicitly; this keeps it in flops rather than RAM.
            for (int i = 0; i < NVOICES; i++) begin
                active_tab[i] <= 1'b0;
                midi_tab[i]   <= '0;
                inc_tab[i]    <= '0;
                phase_tab[i]  <= '0;
            end
            slot    <= '0;
            o_voice <= '0;
            o_valid <= 1'b0;
            o_midi  <= '0;
            o_phase <= '0;
        end else begin
            if (clk_en) begin
                o_voice <= slot;
                o_valid <= active_tab[slot] && !i_all_off;
                o_midi  <= midi_tab[slot];
                o_phase <= phase_tab[slot];
                if (active_tab[slot]) begin
                    phase_tab[slot] <= phase_tab[slot] + inc_tab[slot];
                end
                slot <= (slot == LAST_SLOT) ? '0 : slot + VIDX_W'(1);
            end

            // NOTE: later non-blocking writes to the same entry override
            // earlier ones, so the order below sets the priority:
            // issue update < commit write < panic clear.
            if (do_retrig) begin
                inc_tab[commit_idx]   <= cmd_inc;
                phase_tab[commit_idx] <= '0;
            end
            if (do_alloc) begin
                active_tab[commit_idx] <= 1'b1;
                midi_tab[commit_idx]   <= cmd_midi;
                inc_tab[commit_idx]    <= cmd_inc;
                phase_tab[commit_idx]  <= '0;
            end
            if (do_off) begin
                active_tab[commit_idx] <= 1'b0;
                phase_tab[commit_idx]  <= '0;
            end
            if (i_all_off) begin
                for (int i = 0; i < NVOICES; i++) begin
                    active_tab[i] <= 1'b0;
                    phase_tab[i]  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_slot_scheduler.sv
// Directed self-checking bench for voice_slot_scheduler.
module tb_voice_slot_scheduler;

    localparam int NVOICES = 10;
    localparam int VIDX_W  = 4;
    localparam int PHASE_W = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_en;
    logic               i_cmd_valid;
    logic               o_cmd_ready;
    logic               i_cmd_on;
    logic [6:0]         i_cmd_midi;
    logic [PHASE_W-1:0] i_cmd_inc;
    logic               i_all_off;
    logic [PHASE_W-1:0] o_phase;
    logic [6:0]         o_midi;
    logic               o_valid;
    logic [VIDX_W-1:0]  o_voice;
    logic               o_drop;

    int total = 0;
    int bad   = 0;

    voice_slot_scheduler #(
        .NVOICES(NVOICES),
        .VIDX_W (VIDX_W),
        .PHASE_W(PHASE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_on   (i_cmd_on),
        .i_cmd_midi (i_cmd_midi),
        .i_cmd_inc  (i_cmd_inc),
        .i_all_off  (i_all_off),
        .o_phase    (o_phase),
        .o_midi     (o_midi),
        .o_valid    (o_valid),
        .o_voice    (o_voice),
        .o_drop     (o_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and wait until the FSM is ready again.
    task automatic send_cmd(input logic on, input logic [6:0] midi, input logic [PHASE_W-1:0] inc,
                            output int low_cycles, output int drops);
        int guard;
        low_cycles = 0;
        drops      = 0;
        guard      = 0;
        while (!o_cmd_ready && guard < 50) begin
            step();
            guard++;
        end
        i_cmd_valid = 1'b1;
        i_cmd_on    = on;
        i_cmd_midi  = midi;
        i_cmd_inc   = inc;
        step();
        i_cmd_valid = 1'b0;
        while (!o_cmd_ready && low_cycles < 50) begin
            low_cycles++;
            if (o_drop) drops++;
            step();
        end
        if (o_drop) drops++;
    endtask

    // Advance at least one edge, until slot v is on the issue outputs.
    task automatic wait_slot(input int v);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (o_voice != VIDX_W'(v) && n < 40);
        check("slot_reach", 32'(o_voice), 32'(v));
    endtask

    int lc, dr, cnt;

    initial begin
        rst         = 1'b0;
        clk_en      = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_on    = 1'b0;
        i_cmd_midi  = '0;
        i_cmd_inc   = '0;
        i_all_off   = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_phase", 32'(o_phase), 0);
        check("rst_midi",  32'(o_midi), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_voice", 32'(o_voice), 0);
        check("rst_drop",  32'(o_drop), 0);
        check("rst_ready", 32'(o_cmd_ready), 1);

        // Idle round robin
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            check("idle_voice", 32'(o_voice), 32'(i % NVOICES));
            check("idle_valid", 32'(o_valid), 0);
            check("idle_ready", 32'(o_cmd_ready), 1);
        end

        // Note-on 69 -> slot 0, phases step by 0x100
        send_cmd(1'b1, 7'd69, 24'h000100, lc, dr);
        check("on69_busy", 32'(lc), 11);
        check("on69_drop", 32'(dr), 0);
        wait_slot(0);
        check("s0_valid", 32'(o_valid), 1);
        check("s0_midi",  32'(o_midi), 69);
        check("s0_ph0",   32'(o_phase), 32'h000000);
        wait_slot(0);
        check("s0_ph1",   32'(o_phase), 32'h000100);
        wait_slot(0);
        check("s0_ph2",   32'(o_phase), 32'h000200);

        // Note-on 60 -> slot 1, wraps after two steps; freeze with clk_en low
        send_cmd(1'b1, 7'd60, 24'h800000, lc, dr);
        check("on60_busy", 32'(lc), 11);
        wait_slot(1);
        check("s1_midi", 32'(o_midi), 60);
        check("s1_ph0",  32'(o_phase), 32'h000000);
        wait_slot(1);
        check("s1_ph1",  32'(o_phase), 32'h800000);
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("frz_voice", 32'(o_voice), 1);
            check("frz_phase", 32'(o_phase), 32'h800000);
            check("frz_valid", 32'(o_valid), 1);
        end
        clk_en = 1'b1;
        wait_slot(1);
        check("s1_wrap", 32'(o_phase), 32'h000000);

        // Fill slots 2..9 with notes 70..77
        for (int i = 0; i < 8; i++) begin
            send_cmd(1'b1, 7'(70 + i), 24'h000010, lc, dr);
            check("fill_drop", 32'(dr), 0);
        end
        // Table full: 11th note is dropped for exactly one cycle
        send_cmd(1'b1, 7'd100, 24'h000010, lc, dr);
        check("full_busy", 32'(lc), 11);
        check("full_drop", 32'(dr), 1);
        step();
        check("drop_pulse_end", 32'(o_drop), 0);
        for (int i = 0; i < NVOICES; i++) begin
            step();
            check("full_valid", 32'(o_valid), 1);
            check("full_no100", 32'(o_midi == 7'd100), 0);
        end

        // Note-off 69 frees slot 0; note-off 127 changes nothing
        send_cmd(1'b0, 7'd69, '0, lc, dr);
        check("off69_drop", 32'(dr), 0);
        for (int i = 0; i < NVOICES; i++) begin
            step();
            check("off69_valid", 32'(o_valid), 32'(o_voice != 0));
        end
        send_cmd(1'b0, 7'd127, '0, lc, dr);
        check("off127_busy", 32'(lc), 11);
        for (int i = 0; i < NVOICES; i++) begin
            step();
            check("off127_valid", 32'(o_valid), 32'(o_voice != 0));
        end

        // Place 69 in slot 3 (slot 0 taken by 50), then retrigger it
        send_cmd(1'b0, 7'd71, '0, lc, dr);
        send_cmd(1'b1, 7'd50, 24'h000010, lc, dr);
        send_cmd(1'b1, 7'd69, 24'h000100, lc, dr);
        wait_slot(3);
        check("s3_midi", 32'(o_midi), 69);
        check("s3_ph0",  32'(o_phase), 32'h000000);
        wait_slot(3);
        check("s3_ph1",  32'(o_phase), 32'h000100);
        send_cmd(1'b1, 7'd69, 24'h001000, lc, dr);
        check("retrig_drop", 32'(dr), 0);
        wait_slot(3);
        check("retrig_valid", 32'(o_valid), 1);
        check("retrig_midi",  32'(o_midi), 69);
        check("retrig_ph0",   32'(o_phase), 32'h000000);
        wait_slot(3);
        check("retrig_ph1",   32'(o_phase), 32'h001000);
        cnt = 0;
        for (int i = 0; i < NVOICES; i++) begin
            step();
            if (o_valid && o_midi == 7'd69) cnt++;
        end
        check("retrig_single", 32'(cnt), 1);

        // Panic during SEARCH of a command that would otherwise drop
        i_cmd_valid = 1'b1;
        i_cmd_on    = 1'b1;
        i_cmd_midi  = 7'd100;
        i_cmd_inc   = 24'h000010;
        step();
        i_cmd_valid = 1'b0;
        check("pan_busy", 32'(o_cmd_ready), 0);
        repeat (3) step();
        i_all_off = 1'b1;
        step();
        i_all_off = 1'b0;
        check("pan_ready", 32'(o_cmd_ready), 1);
        check("pan_valid", 32'(o_valid), 0);
        check("pan_drop",  32'(o_drop), 0);
        for (int i = 0; i < 14; i++) begin
            step();
            check("pan_valid_run", 32'(o_valid), 0);
            check("pan_drop_run",  32'(o_drop), 0);
        end

        // A command presented together with panic is not accepted
        i_cmd_valid = 1'b1;
        i_all_off   = 1'b1;
        step();
        i_cmd_valid = 1'b0;
        i_all_off   = 1'b0;
        check("pan_reject", 32'(o_cmd_ready), 1);

        // Reset during COMMIT clears everything
        send_cmd(1'b1, 7'd40, 24'h000010, lc, dr);
        i_cmd_valid = 1'b1;
        i_cmd_on    = 1'b1;
        i_cmd_midi  = 7'd41;
        step();
        i_cmd_valid = 1'b0;
        repeat (10) step();
        check("commit_busy", 32'(o_cmd_ready), 0);
        rst = 1'b0;
        step();
        check("rst2_phase", 32'(o_phase), 0);
        check("rst2_midi",  32'(o_midi), 0);
        check("rst2_valid", 32'(o_valid), 0);
        check("rst2_voice", 32'(o_voice), 0);
        check("rst2_drop",  32'(o_drop), 0);
        check("rst2_ready", 32'(o_cmd_ready), 1);
        rst = 1'b1;
        for (int i = 0; i < NVOICES; i++) begin
            step();
            check("rst2_voice_run", 32'(o_voice), 32'(i));
            check("rst2_valid_run", 32'(o_valid), 0);
        end
        step();
        check("rst2_ready_run", 32'(o_cmd_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
